// File: rtl/magnitude_iter.sv
// magnitude_iter: multi-cycle vector magnitude engine.
// Accepts DIMS unsigned W-bit components and returns the integer square root of
// their sum of squares. The root is either floor or rounded to nearest. The floor
// remainder (sum - floor_root^2) is also returned. Squaring is shift-add, one
// multiplier bit per cycle. The root is bit-serial restoring, one bit per cycle.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   ena        clock enable; when low all registers hold and no handshake completes
//   in_valid   operand vector valid
//   in_ready   engine idle and able to accept an operand vector
//   in_data    DIMS*W bits; component i at [i*W +: W]
//   in_round   sampled at acceptance: 1 = round-to-nearest root, 0 = floor root
//   out_valid  result valid
//   out_ready  consumer accepts the result
//   out_root   W+1-bit root result
//   out_rem    W+2-bit floor remainder
module magnitude_iter #(
  parameter int W    = 8,
  parameter int DIMS = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DIMS*W-1:0] in_data,
  input  logic              in_round,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W:0]        out_root,
  output logic [W+1:0]      out_rem
);

  localparam int PW  = DIMS * W;          // packed operand width
  localparam int SW  = 2 * W + 2;         // sum-of-squares width
  localparam int RW  = W + 1;             // root width
  localparam int MW  = W + 2;             // remainder width
  localparam int TW  = W + 4;             // root iteration working width
  localparam int BCW = $clog2(W + 1);     // counts 0..W
  localparam int CCW = (DIMS > 1) ? $clog2(DIMS) : 1;

  typedef enum logic [1:0] {IDLE, SQUARE, ROOT, DONE} state_t;

  state_t state, state_nx;

  logic           armed;
  logic [PW-1:0]  vec_sh;
  logic [SW-1:0]  mcand;
  logic [W-1:0]   mplier;
  logic [SW-1:0]  acc;
  logic           round_q;
  logic [BCW-1:0] bit_cnt;
  logic [CCW-1:0] comp_cnt;
  logic [RW-1:0]  root_q;
  logic [MW-1:0]  rem_q;

  logic           accept;
  logic           sq_done;
  logic           root_done;
  logic [SW-1:0]  acc_add;
  logic [TW-1:0]  rem_shift;
  logic [TW-1:0]  trial;
  logic [TW-1:0]  rem_diff;
  logic           root_ge;
  logic [RW-1:0]  root_next;
  logic [MW-1:0]  rem_next;
  logic           round_up;
  logic [RW-1:0]  root_final;

  assign accept    = in_valid && in_ready && ena;
  assign sq_done   = (comp_cnt == CCW'(DIMS - 1)) && (bit_cnt == BCW'(W - 1));
  assign root_done = (bit_cnt == BCW'(W));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else if (ena) begin
      state <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid && in_ready) state_nx = SQUARE;
      SQUARE:  if (sq_done)              state_nx = ROOT;
      ROOT:    if (root_done)            state_nx = DONE;
      DONE:    if (out_ready)            state_nx = IDLE;
      default:                           state_nx = IDLE;
    endcase
  end

  // Output logic; armed keeps in_ready low until the first enabled edge after reset
  always_comb begin
    in_ready  = (state == IDLE) && armed;
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed <= 1'b0;
    end else if (ena) begin
      armed <= 1'b1;
    end
  end

  // Shift-add squaring step
  always_comb begin
    acc_add = mplier[0] ? acc + mcand : acc;
  end

  // Restoring square root step: the next radicand bit pair comes from the top of
  // acc, which is shifted left by two each ROOT cycle.
  always_comb begin
    rem_shift  = {rem_q, acc[SW-1 -: 2]};
    trial      = {1'b0, root_q, 2'b01};
    root_ge    = (rem_shift >= trial);
    rem_diff   = root_ge ? rem_shift - trial : rem_shift;
    rem_next   = MW'(rem_diff);
    root_next  = RW'({root_q, root_ge});
    // m > r is exact round-half-up on sqrt(sum); no tie is possible
    round_up   = round_q && ({1'b0, root_next} < rem_next);
    root_final = round_up ? root_next + RW'(1) : root_next;
  end

  // Datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_sh   <= '0;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      round_q  <= 1'b0;
      bit_cnt  <= '0;
      comp_cnt <= '0;
      root_q   <= '0;
      rem_q    <= '0;
      out_root <= '0;
      out_rem  <= '0;
    end else if (ena) begin
      case (state)
        IDLE: begin
          if (accept) begin
            // Component 0 goes straight into the multiplier; the rest queue up in vec_sh
            vec_sh   <= in_data >> W;
            mcand    <= SW'(in_data[W-1:0]);
            mplier   <= in_data[W-1:0];
            acc      <= '0;
            round_q  <= in_round;
            bit_cnt  <= '0;
            comp_cnt <= '0;
            root_q   <= '0;
            rem_q    <= '0;
          end
        end
        SQUARE: begin
          acc <= acc_add;
          if (bit_cnt == BCW'(W - 1)) begin
            bit_cnt  <= '0;
            comp_cnt <= comp_cnt + CCW'(1);
            mcand    <= SW'(vec_sh[W-1:0]);
            mplier   <= vec_sh[W-1:0];
            vec_sh   <= vec_sh >> W;
          end else begin
            bit_cnt <= bit_cnt + BCW'(1);
            mcand   <= mcand << 1;
            mplier  <= mplier >> 1;
          end
        end
        ROOT: begin
          acc     <= acc << 2;
          root_q  <= root_next;
          rem_q   <= rem_next;
          bit_cnt <= bit_cnt + BCW'(1);
          if (root_done) begin
            out_root <= root_final;
            out_rem  <= rem_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_magnitude_iter.sv
// Testbench for magnitude_iter. Exercises a default instance (W=8, DIMS=2) and a
// DIMS=4 instance, with a scoreboard queue of model results.
module tb_magnitude_iter;

  typedef struct packed {
    logic [8:0] root;
    logic [9:0] rem;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic        in_valid, in_ready, in_round, out_valid, out_ready;
  logic [15:0] in_data;
  logic [8:0]  out_root;
  logic [9:0]  out_rem;

  logic        in_valid4, in_ready4, out_valid4;
  logic [31:0] in_data4;
  logic [8:0]  out_root4;
  logic [9:0]  out_rem4;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  magnitude_iter #(.W(8), .DIMS(2)) u_dut (
    .clk(clk), .rst(rst), .ena(ena),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_round(in_round),
    .out_valid(out_valid), .out_ready(out_ready), .out_root(out_root), .out_rem(out_rem)
  );

  magnitude_iter #(.W(8), .DIMS(4)) u_dut4 (
    .clk(clk), .rst(rst), .ena(ena),
    .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4), .in_round(1'b0),
    .out_valid(out_valid4), .out_ready(1'b1), .out_root(out_root4), .out_rem(out_rem4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic exp_t model(input int unsigned sum, input bit rnd);
    exp_t        e;
    int unsigned r;
    int unsigned m;
    r = 0;
    while ((r + 1) * (r + 1) <= sum) r++;
    m = sum - r * r;
    if (rnd && m > r) r++;
    e.root = 9'(r);
    e.rem  = 10'(m);
    return e;
  endfunction

  task automatic wait_ready;
    int n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    check("in_ready_wait", 32'(in_ready), 1);
  endtask

  // One operation on the default instance. hold: cycles of out_ready low once
  // out_valid is seen. drop_at: edge after acceptance where ena drops for 7 cycles.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input bit rnd,
                       input int exp_lat, input int hold, input int drop_at);
    exp_t        e;
    int          n;
    bit          saw_rdy;
    bit          unstable;
    int unsigned sum;
    wait_ready();
    sum      = int'(a) * int'(a) + int'(b) * int'(b);
    in_data  = {b, a};
    in_round = rnd;
    in_valid = 1'b1;
    sb.push_back(model(sum, rnd));
    tick();
    in_valid = 1'b0;
    in_data  = 16'($urandom);
    in_round = ~rnd;
    n        = 0;
    saw_rdy  = 1'b0;
    while (!out_valid && n < 200) begin
      tick();
      n++;
      if (in_ready) saw_rdy = 1'b1;
      if (drop_at > 0 && n == drop_at) ena = 1'b0;
      if (drop_at > 0 && n == drop_at + 7) ena = 1'b1;
    end
    check("latency", 32'(n), 32'(exp_lat));
    check("in_ready_busy", 32'(saw_rdy), 0);
    e = sb[0];
    if (hold > 0) begin
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 16'h0101;
      unstable  = 1'b0;
      for (int i = 0; i < hold; i++) begin
        tick();
        if (!out_valid || in_ready || out_root !== e.root || out_rem !== e.rem) unstable = 1'b1;
      end
      check("hold_stable", 32'(unstable), 0);
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    e = sb.pop_front();
    check("root", 32'(out_root), 32'(e.root));
    check("rem", 32'(out_rem), 32'(e.rem));
    tick();
    check("valid_clear", 32'(out_valid), 0);
    check("ready_back", 32'(in_ready), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   n;
    bit   saw;
    exp_t e;
    rst       = 1'b1;
    ena       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_round  = 1'b0;
    out_ready = 1'b1;
    in_valid4 = 1'b0;
    in_data4  = '0;
    tick();
    tick();
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_root", 32'(out_root), 0);
    check("rst_out_rem", 32'(out_rem), 0);
    rst = 1'b0;
    #1;
    check("in_ready_pre_edge", 32'(in_ready), 0);
    tick();
    check("in_ready_first_edge", 32'(in_ready), 1);

    do_op(8'd3,   8'd4,   1'b0, 25, 0, 0);
    do_op(8'd255, 8'd255, 1'b0, 25, 0, 0);
    do_op(8'd255, 8'd255, 1'b1, 25, 0, 0);
    do_op(8'd2,   8'd3,   1'b1, 25, 0, 0);
    do_op(8'd2,   8'd3,   1'b0, 25, 0, 0);
    do_op(8'd1,   8'd1,   1'b1, 25, 0, 0);
    do_op(8'd0,   8'd0,   1'b1, 25, 0, 0);
    // Backpressure, then an immediate follow-up operation
    do_op(8'd7,   8'd24,  1'b1, 25, 10, 0);
    do_op(8'd5,   8'd12,  1'b0, 25, 0, 0);
    // ena low for 7 cycles during ROOT
    do_op(8'd100, 8'd200, 1'b1, 32, 0, 18);

    // Reset mid-SQUARE discards the operation
    wait_ready();
    in_data  = {8'd9, 8'd9};
    in_round = 1'b0;
    in_valid = 1'b1;
    sb.push_back(model(162, 1'b0));
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    #1;
    check("abort_out_valid", 32'(out_valid), 0);
    check("abort_in_ready", 32'(in_ready), 0);
    check("abort_out_root", 32'(out_root), 0);
    check("abort_out_rem", 32'(out_rem), 0);
    sb.delete();
    tick();
    rst = 1'b0;
    tick();
    check("abort_ready_back", 32'(in_ready), 1);
    saw = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid) saw = 1'b1;
    end
    check("abort_no_stale", 32'(saw), 0);
    do_op(8'd3, 8'd4, 1'b0, 25, 0, 0);

    // DIMS=4 instance, all components at full scale
    n = 0;
    while (!in_ready4 && n < 100) begin
      tick();
      n++;
    end
    check("d4_ready", 32'(in_ready4), 1);
    in_data4  = '1;
    in_valid4 = 1'b1;
    sb.push_back(model(4 * 255 * 255, 1'b0));
    tick();
    in_valid4 = 1'b0;
    in_data4  = '0;
    n = 0;
    while (!out_valid4 && n < 200) begin
      tick();
      n++;
    end
    check("d4_latency", 32'(n), 41);
    e = sb.pop_front();
    check("d4_root", 32'(out_root4), 32'(e.root));
    check("d4_rem", 32'(out_rem4), 32'(e.rem));
    tick();
    check("d4_valid_clear", 32'(out_valid4), 0);

    check("sb_empty", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
